// File: rtl/xs_arbiter.sv
// xs_arbiter: two-requester round-robin front end for a single XOR-shift unit.
// A granted operand pair is latched, computed in one EXEC cycle and held on the
// result port until the consumer takes it.
//
// Handshake rule for every port: a transfer happens on a rising clk edge where
// valid and ready are both high. valid never waits on ready. A result, once
// valid, keeps res_data/res_id stable until it is transferred.
module xs_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic [CNT_W-1:0] done_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             ptr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_id;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [WIDTH-1:0] x_val;
    logic [WIDTH-1:0] c_val;

    // Grant: a lone requester always wins; on contention the pointer decides.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !ptr);
        grant1 = req1_valid && (!req0_valid || ptr);
    end

    // Ready is only offered in IDLE and is forced low while reset is asserted.
    assign req0_ready = rst_n && (state == IDLE) && grant0;
    assign req1_ready = rst_n && (state == IDLE) && grant1;
    assign accept     = req0_ready || req1_ready;

    assign res_valid  = (state == HOLD);
    assign busy       = (state != IDLE);

    // XOR of the latched operands, shifted left when A's MSB is set.
    always_comb begin
        x_val = op_a ^ op_b;
        c_val = x_val;
        if (op_a[WIDTH-1]) begin
            c_val = {x_val[WIDTH-2:0], 1'b0};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: IDLE -> EXEC on accept, EXEC -> HOLD, HOLD -> IDLE on handshake.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = HOLD;
            HOLD:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and pointer rotation on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            op_id <= 1'b0;
            ptr   <= 1'b0;
        end else if (accept) begin
            op_a  <= req1_ready ? req1_a : req0_a;
            op_b  <= req1_ready ? req1_b : req0_b;
            op_id <= req1_ready;
            ptr   <= !req1_ready;
        end
    end

    // Result register loaded in EXEC and completion counter stepped on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data   <= '0;
            res_id     <= 1'b0;
            done_count <= '0;
        end else begin
            if (state == EXEC) begin
                res_data <= c_val;
                res_id   <= op_id;
            end
            if ((state == HOLD) && res_ready) begin
                done_count <= done_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_xs_arbiter.sv
// tb_xs_arbiter: directed bench for xs_arbiter with a result scoreboard.
module tb_xs_arbiter;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_id;
    logic             res_ready;
    logic [CNT_W-1:0] done_count;
    logic             busy;

    int comp_cnt = 0;
    int fail_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic             id_q[$];
    logic [CNT_W-1:0] exp_cnt;

    xs_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
        .done_count(done_count), .busy(busy)
    );

    // Clock generation.
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        x = a ^ b;
        if (a[WIDTH-1]) return {x[WIDTH-2:0], 1'b0};
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic id, input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b;
        end
    endtask

    // Lone request from one side, full pass through EXEC and HOLD, immediate handshake.
    task automatic do_txn(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_c);
        set_req(id, 1'b1, a, b);
        #1;
        check("ready_granted", 32'(id ? req1_ready : req0_ready), 32'd1);
        check("ready_other",   32'(id ? req0_ready : req1_ready), 32'd0);
        tick;
        set_req(id, 1'b0, ~a, ~b);
        check("exec_busy",  32'(busy), 32'd1);
        check("exec_valid", 32'(res_valid), 32'd0);
        tick;
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data",  32'(res_data), 32'(exp_c));
        check("hold_id",    32'(res_id), 32'(id));
        res_ready = 1'b1;
        tick;
        exp_cnt = exp_cnt + CNT_W'(1);
        res_ready = 1'b0;
        check("done_count", 32'(done_count), 32'(exp_cnt));
        check("post_valid", 32'(res_valid), 32'd0);
        check("post_busy",  32'(busy), 32'd0);
    endtask

    initial begin
        logic exp_id;
        logic fin;
        int   n_acc, n_res;
        logic [WIDTH-1:0] got;

        req0_valid = 1'b1; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        exp_cnt = '0;

        // Reset values, including ready held low despite a valid request.
        #1;
        check("rst_res_valid",  32'(res_valid), 32'd0);
        check("rst_res_data",   32'(res_data), 32'd0);
        check("rst_res_id",     32'(res_id), 32'd0);
        check("rst_done_count", 32'(done_count), 32'd0);
        check("rst_busy",       32'(busy), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b1;

        // Basic transactions; the last one is a lone req0 while the pointer favours req1.
        do_txn(1'b0, 8'h55, 8'h33, 8'h66);
        do_txn(1'b1, 8'hD5, 8'h33, 8'hCC);
        do_txn(1'b0, 8'hFF, 8'hFF, 8'h00);
        do_txn(1'b0, 8'h80, 8'h01, 8'h02);

        // Back-pressure in HOLD: result stable, no grants, inputs changed after accept.
        set_req(1'b0, 1'b1, 8'h3C, 8'h0F);
        #1;
        check("stall_accept", 32'(req0_ready), 32'd1);
        tick;
        set_req(1'b0, 1'b1, 8'hFF, 8'h00);
        set_req(1'b1, 1'b1, 8'h12, 8'h34);
        tick;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid",  32'(res_valid), 32'd1);
            check("stall_data",   32'(res_data), 32'h33);
            check("stall_id",     32'(res_id), 32'd0);
            check("stall_busy",   32'(busy), 32'd1);
            check("stall_ready0", 32'(req0_ready), 32'd0);
            check("stall_ready1", 32'(req1_ready), 32'd0);
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        tick;
        exp_cnt = exp_cnt + CNT_W'(1);
        check("stall_release_cnt",   32'(done_count), 32'(exp_cnt));
        check("stall_release_valid", 32'(res_valid), 32'd0);
        tick;
        res_ready = 1'b0;
        check("stall_single_cnt", 32'(done_count), 32'(exp_cnt));

        // Asynchronous reset while in HOLD; pointer was left on req1.
        set_req(1'b0, 1'b1, 8'hA0, 8'h0A);
        tick;
        set_req(1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        check("pre_rst_valid", 32'(res_valid), 32'd1);
        check("pre_rst_data",  32'(res_data), 32'h54);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(res_valid), 32'd0);
        check("async_busy",  32'(busy), 32'd0);
        check("async_cnt",   32'(done_count), 32'd0);
        check("async_data",  32'(res_data), 32'd0);
        check("async_id",    32'(res_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = '0;

        // Both requesters valid from reset: alternate 0,1,0,1, never both ready.
        set_req(1'b0, 1'b1, 8'h12, 8'h34);
        set_req(1'b1, 1'b1, 8'h9A, 8'h0F);
        res_ready = 1'b1;
        exp_id = 1'b0; n_acc = 0; n_res = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("ready_exclusive", 32'(req0_ready & req1_ready), 32'd0);
            if (req0_ready || req1_ready) begin
                check("accept_order", 32'(req1_ready), 32'(exp_id));
                exp_q.push_back(req1_ready ? model(req1_a, req1_b) : model(req0_a, req0_b));
                id_q.push_back(req1_ready);
                exp_id = ~exp_id;
                n_acc++;
            end
            if (res_valid) begin
                check("rr_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check("rr_data", 32'(res_data), 32'(got));
                    check("rr_id",   32'(res_id), 32'(id_q.pop_front()));
                end
                n_res++;
                exp_cnt = exp_cnt + CNT_W'(1);
            end
            tick;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        check("rr_accepts", 32'(n_acc), 32'd4);
        check("rr_results", 32'(n_res), 32'd4);
        check("rr_count",   32'(done_count), 32'(exp_cnt));

        // 256 back-to-back transactions from req0: counter wraps to zero.
        rst_n = 1'b0;
        #1;
        check("rst2_cnt", 32'(done_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        res_ready = 1'b1;
        req0_valid = 1'b1;
        n_acc = 0; n_res = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            req0_a = WIDTH'(n_acc * 37 + 11);
            req0_b = WIDTH'(n_acc * 13) ^ 8'hA5;
            #1;
            if (req0_ready) begin
                exp_q.push_back(model(req0_a, req0_b));
                n_acc++;
            end
            if (res_valid) begin
                check("wrap_queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check("wrap_data", 32'(res_data), 32'(got));
                end
                check("wrap_id", 32'(res_id), 32'd0);
                n_res++;
                if (n_res == 256) begin
                    check("cnt_before_wrap", 32'(done_count), 32'hFF);
                    fin = 1'b1;
                end
            end
            tick;
        end
        req0_valid = 1'b0;
        res_ready = 1'b0;
        check("wrap_results", 32'(n_res), 32'd256);
        check("wrap_accepts", 32'(n_acc), 32'd256);
        check("wrap_count",   32'(done_count), 32'd0);
        check("wrap_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
        $finish;
    end

endmodule
